job_sequencer: RTL and testbench
================================

Name: job_sequencer

Overview:
- Host-side run controller sitting directly upstream of the processor top level.
- Drives the processor's init and req inputs and watches its ack output.
- On a host start request it resets the core, issues req, and waits for ack.
- Reports the run's cycle count, completion, and an optional timeout to the host through a start/done/result_ack handshake.

Parameters:
INIT_CYC, 4, number of cycles proc_init is held high before req is issued (legal range 1..255)
CW, 16, width of the run-cycle counter and cycle_count output
TIMEOUT, 1000, maximum RUN cycles before a forced abort (used only with the optional feature; must be at least 1 and at most 2^CW-1)
JW, 8, width of the completed-job counter

Ports:
Clk  input  1  system clock; all state updates on its rising edge
Reset  input  1  synchronous, active-high reset
start  input  1  host request to begin a job; sampled only in IDLE
result_ack  input  1  host acknowledges the result; sampled only in DONE
proc_ack  input  1  processor completion flag (the processor's ack)
proc_init  output  1  processor reset (drives the processor's init)
proc_req  output  1  processor start request (drives the processor's req)
busy  output  1  high in the INIT and RUN states
done  output  1  high in the DONE state
timed_out  output  1  result flag: run ended by timeout, not by ack
cycle_count  output  CW  number of RUN cycles of the last job
jobs_done  output  JW  count of completed jobs

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high.
- States: IDLE, INIT, RUN, DONE. The state register is 2 bits. All outputs are registered or decoded from state, except proc_init.
- proc_init = Reset OR (state==INIT), so the processor is held in reset whenever this block is in reset.
- Reset, at the clock edge with Reset=1:
  - state goes to IDLE.
  - busy=0, done=0, proc_req=0, timed_out=0, cycle_count=0, jobs_done=0.
  - The init counter and run counter are cleared.
  - Reset mid-job aborts the job immediately, with no DONE and no jobs_done increment.
- IDLE:
  - start=1 moves to INIT and loads the init counter with INIT_CYC-1.
  - proc_ack is ignored.
- INIT:
  - proc_init=1 for exactly INIT_CYC consecutive cycles. The counter decrements each cycle.
  - When the counter reaches 0, move to RUN and clear the run counter.
  - start and proc_ack are ignored.
- RUN:
  - proc_req=1 for every cycle spent in RUN. The run counter increments each RUN cycle and saturates at 2^CW-1.
  - If proc_ack=1 at an edge, move to DONE. cycle_count latches (run counter + 1, saturating), which is the number of RUN cycles including the ack cycle. timed_out latches 0. jobs_done increments and wraps modulo 2^JW.
  - A proc_ack already high on the first RUN cycle is honoured, giving cycle_count=1.
- DONE:
  - done=1 and proc_req=0. cycle_count and timed_out hold stable.
  - result_ack=1 moves to IDLE.
  - start is ignored.
  - cycle_count and timed_out keep their values in IDLE until the next job latches new ones.
- Latency from start to the first proc_req cycle is INIT_CYC+1 edges.
- Simultaneous start and result_ack in DONE: result_ack wins, and start is not remembered.

Optional Feature:
- Macro JOB_SEQ_TIMEOUT_EN.
- Enabled:
  - In RUN, if the run counter equals TIMEOUT-1 and proc_ack=0, move to DONE with timed_out=1 and cycle_count=TIMEOUT. jobs_done does not increment.
  - If proc_ack=1 on that same cycle, ack wins: timed_out=0, cycle_count=TIMEOUT, jobs_done increments.
- Disabled:
  - No timeout logic is synthesised. timed_out is tied to 0, and RUN waits indefinitely with a saturating counter.

Test Plan:
- Reset, then start pulse at cycle 0 with INIT_CYC=4 -> proc_init high in cycles 1-4, proc_req rises in cycle 5, busy=1 in cycles 1 onward.
- proc_ack raised on the 10th RUN cycle -> done=1 next cycle, cycle_count=10, timed_out=0, jobs_done=1, proc_req=0. Then result_ack -> IDLE, values retained.
- proc_ack held high from the first RUN cycle -> cycle_count=1. Start asserted in INIT and DONE -> no effect.
- With JOB_SEQ_TIMEOUT_EN and TIMEOUT=20, no ack -> DONE after 20 RUN cycles, timed_out=1, cycle_count=20, jobs_done unchanged. A second case with ack exactly on RUN cycle 20 -> timed_out=0.
- Reset asserted in the 3rd RUN cycle -> next cycle IDLE, proc_init=1 during Reset, proc_req=0, done=0, jobs_done=0. A fresh start then runs normally.
- JW=8, 256 back-to-back jobs -> jobs_done wraps to 0.

Source files
------------

// File: rtl/job_sequencer.sv
// Host-side run controller: resets the core, issues req, waits for ack.
// Optional run timeout enabled by defining JOB_SEQ_TIMEOUT_EN.
module job_sequencer #(
  parameter int unsigned INIT_CYC = 4,
  parameter int unsigned CW       = 16,
  parameter int unsigned TIMEOUT  = 1000,
  parameter int unsigned JW       = 8
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          start,
  input  logic          result_ack,
  input  logic          proc_ack,
  output logic          proc_init,
  output logic          proc_req,
  output logic          busy,
  output logic          done,
  output logic          timed_out,
  output logic [CW-1:0] cycle_count,
  output logic [JW-1:0] jobs_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_INIT = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [7:0] INIT_LOAD = 8'(INIT_CYC - 1);

  if (INIT_CYC < 1 || INIT_CYC > 255) begin : g_bad_init
    $error("job_sequencer: INIT_CYC must be 1..255");
  end
  if (TIMEOUT < 1 || 64'(TIMEOUT) > ((64'd1 << CW) - 64'd1)) begin : g_bad_to
    $error("job_sequencer: TIMEOUT must be 1..2^CW-1");
  end

  state_t        state_q;
  state_t        state_d;
  logic [7:0]    init_cnt;
  logic [CW-1:0] run_cnt;
  logic [CW-1:0] run_inc;
  logic          ack_hit;
  logic          to_hit;

  assign run_inc = (&run_cnt) ? run_cnt : run_cnt + 1'b1;
  assign ack_hit = (state_q == S_RUN) && proc_ack;

`ifdef JOB_SEQ_TIMEOUT_EN
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  logic to_q;

  assign to_hit    = (state_q == S_RUN) && !proc_ack && (run_cnt == TO_LAST);
  assign timed_out = to_q;

  always_ff @(posedge Clk) begin
    if (Reset)        to_q <= 1'b0;
    else if (ack_hit) to_q <= 1'b0;
    else if (to_hit)  to_q <= 1'b1;
  end
`else
  assign to_hit    = 1'b0;
  assign timed_out = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_INIT;
      S_INIT:  if (init_cnt == 8'd0) state_d = S_RUN;
      S_RUN:   if (ack_hit || to_hit) state_d = S_DONE;
      S_DONE:  if (result_ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      init_cnt    <= 8'd0;
      run_cnt     <= '0;
      cycle_count <= '0;
      jobs_done   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start)
        init_cnt <= INIT_LOAD;
      else if (state_q == S_INIT && init_cnt != 8'd0)
        init_cnt <= init_cnt - 8'd1;
      // Held clear through INIT so RUN always starts from zero
      if (state_q == S_INIT)
        run_cnt <= '0;
      else if (state_q == S_RUN)
        run_cnt <= run_inc;
      if (ack_hit || to_hit)
        cycle_count <= run_inc;
      if (ack_hit)
        jobs_done <= jobs_done + 1'b1;
    end
  end

  assign proc_init = Reset || (state_q == S_INIT);
  assign proc_req  = (state_q == S_RUN);
  assign busy      = (state_q == S_INIT) || (state_q == S_RUN);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_job_sequencer.sv
// Self-checking bench for job_sequencer: job table plus scoreboard,
// with hand-written reset-abort and counter-wrap sequences.
`timescale 1ns/1ps
module tb_job_sequencer;

  localparam int CW       = 16;
  localparam int JW       = 8;
  localparam int INIT_CYC = 4;
  localparam int TIMEOUT  = 20;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          start;
  logic          result_ack;
  logic          proc_ack;
  logic          proc_init;
  logic          proc_req;
  logic          busy;
  logic          done;
  logic          timed_out;
  logic [CW-1:0] cycle_count;
  logic [JW-1:0] jobs_done;

  job_sequencer #(
    .INIT_CYC(INIT_CYC),
    .CW(CW),
    .TIMEOUT(TIMEOUT),
    .JW(JW)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .start(start),
    .result_ack(result_ack),
    .proc_ack(proc_ack),
    .proc_init(proc_init),
    .proc_req(proc_req),
    .busy(busy),
    .done(done),
    .timed_out(timed_out),
    .cycle_count(cycle_count),
    .jobs_done(jobs_done)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int ack_cyc;
    bit ack_early;
    bit start_in_init;
    bit start_in_done;
  } job_t;

  typedef struct {
    int cc;
    bit to;
    int jobs;
  } exp_t;

  exp_t sb[$];
  job_t jobs[4];
  int   n_chk;
  int   n_fail;
  int   exp_jobs;

  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic run_job(input job_t j, input bit full);
    exp_t e;
    exp_t got;
    int   k;
    bit   seen;
    e.cc = j.ack_cyc;
    e.to = 1'b0;
`ifdef JOB_SEQ_TIMEOUT_EN
    if (j.ack_cyc > TIMEOUT) begin
      e.cc = TIMEOUT;
      e.to = 1'b1;
    end
`endif
    if (!e.to) exp_jobs = (exp_jobs + 1) % (1 << JW);
    e.jobs = exp_jobs;
    sb.push_back(e);

    start    = 1'b1;
    proc_ack = j.ack_early;
    step();
    start = j.start_in_init;
    for (int i = 1; i <= INIT_CYC; i++) begin
      if (full) begin
        chk("init_proc_init", proc_init, 1);
        chk("init_busy", busy, 1);
        chk("init_req", proc_req, 0);
      end
      step();
    end
    start = 1'b0;
    if (full) begin
      chk("run_req", proc_req, 1);
      chk("run_init", proc_init, 0);
    end
    k    = 1;
    seen = 1'b0;
    for (int c = 0; c < 300 && !seen; c++) begin
      if (done) seen = 1'b1;
      else begin
        proc_ack = (k == j.ack_cyc);
        step();
        k++;
      end
    end
    proc_ack = 1'b0;
    if (!seen) chk("done_reached", done, 1);

    got = sb.pop_front();
    chk("cycle_count", cycle_count, got.cc);
    chk("timed_out", timed_out, got.to);
    chk("jobs_done", jobs_done, got.jobs);
    if (full) begin
      chk("done_req", proc_req, 0);
      chk("done_busy", busy, 0);
    end
    if (j.start_in_done) begin
      start = 1'b1;
      step();
      chk("done_ignore_start", done, 1);
      chk("done_cc_hold", cycle_count, got.cc);
    end
    result_ack = 1'b1;
    step();
    result_ack = 1'b0;
    start      = 1'b0;
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    if (full) begin
      step();
      chk("idle_stays", busy, 0);
      chk("idle_cc_keep", cycle_count, got.cc);
      chk("idle_to_keep", timed_out, got.to);
    end
  endtask

  initial begin
    n_chk      = 0;
    n_fail     = 0;
    exp_jobs   = 0;
    Reset      = 1'b1;
    start      = 1'b0;
    result_ack = 1'b0;
    proc_ack   = 1'b0;
    jobs[0] = '{ack_cyc: 10, ack_early: 1'b0, start_in_init: 1'b0, start_in_done: 1'b0};
    jobs[1] = '{ack_cyc: 1,  ack_early: 1'b1, start_in_init: 1'b1, start_in_done: 1'b1};
    jobs[2] = '{ack_cyc: 25, ack_early: 1'b0, start_in_init: 1'b0, start_in_done: 1'b0};
    jobs[3] = '{ack_cyc: 20, ack_early: 1'b0, start_in_init: 1'b0, start_in_done: 1'b1};

    @(negedge Clk);
    step();
    chk("rst_proc_init", proc_init, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_req", proc_req, 0);
    chk("rst_to", timed_out, 0);
    chk("rst_cc", cycle_count, 0);
    chk("rst_jobs", jobs_done, 0);
    Reset = 1'b0;
    step();
    chk("idle_proc_init", proc_init, 0);

    for (int t = 0; t < 4; t++) run_job(jobs[t], 1'b1);

    // Reset in the third RUN cycle aborts the job
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (INIT_CYC) step();
    step();
    step();
    chk("abort_in_run", proc_req, 1);
    Reset = 1'b1;
    #1;
    chk("abort_init_comb", proc_init, 1);
    step();
    chk("abort_busy", busy, 0);
    chk("abort_req", proc_req, 0);
    chk("abort_done", done, 0);
    chk("abort_jobs", jobs_done, 0);
    chk("abort_init", proc_init, 1);
    Reset    = 1'b0;
    exp_jobs = 0;
    #1;
    chk("abort_init_rel", proc_init, 0);
    step();
    run_job('{ack_cyc: 7, ack_early: 1'b0, start_in_init: 1'b0, start_in_done: 1'b0}, 1'b1);

    // 256 back-to-back jobs wrap the job counter
    Reset = 1'b1;
    step();
    Reset    = 1'b0;
    exp_jobs = 0;
    step();
    for (int n = 0; n < 256; n++)
      run_job('{ack_cyc: 1 + (n % 3), ack_early: 1'b0, start_in_init: 1'b0, start_in_done: 1'b0}, 1'b0);
    chk("jobs_wrap", jobs_done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
